// File: rtl/dds_time_ctrl_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_time_pkg
// Description : Shared state encoding and default sizing for the multi-channel
//               DDS trigger/timing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dds_time_pkg;

    localparam int c_CNT_W_DEF   = 16;
    localparam int c_TIMEOUT_DEF = 65535;

    // One-hot channel state
    typedef enum logic [3:0] {
        ST_IDLE        = 4'b0001,
        ST_WAIT_DROVER = 4'b0010,
        ST_HALF1       = 4'b0100,
        ST_HALF2       = 4'b1000
    } state_e;

endpackage
`default_nettype wire

// File: rtl/dds_time_ctrl_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : dds_time_ctrl_mc_if
// Description : Control/status bundle between the controller and its host /
//               AD9910 pins. master = stimulus side, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface dds_time_ctrl_mc_if #(
    parameter int CH    = 2,
    parameter int CNT_W = 16
);
    logic [CH-1:0]    en;
    logic [CH-1:0]    sweep_sel;
    logic [CNT_W-1:0] pulse_len;
    logic             err_clr;
    logic [CH-1:0]    io_update;
    logic [CH-1:0]    drover;
    logic [CH-1:0]    drctl;
    logic [CH-1:0]    drhold;
    logic [CH-1:0]    osk;
    logic [CH-1:0]    busy;
    logic [CH-1:0]    timeout_err;
    logic [CH-1:0]    cfg_err;

    modport master (
        output en, sweep_sel, pulse_len, err_clr, io_update, drover,
        input  drctl, drhold, osk, busy, timeout_err, cfg_err
    );

    modport slave (
        input  en, sweep_sel, pulse_len, err_clr, io_update, drover,
        output drctl, drhold, osk, busy, timeout_err, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/dds_time_ctrl_mc_chan.sv
`default_nettype none
// ============================================================================
// Module      : dds_time_chan
// Description : One DDS timing channel: input synchronisers, edge detect,
//               IDLE/WAIT_DROVER/HALF1/HALF2 FSM, counters, registered
//               outputs and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_time_chan
    import dds_time_pkg::*;
#(
    parameter int CNT_W       = c_CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = c_TIMEOUT_DEF
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_en,
    input  wire logic             i_sweep_sel,
    input  wire logic [CNT_W-1:0] i_pulse_len,
    input  wire logic             i_err_clr,
    input  wire logic             i_io_update,
    input  wire logic             i_drover,
    output logic                  o_drctl,
    output logic                  o_drhold,
    output logic                  o_osk,
    output logic                  o_busy,
    output logic                  o_timeout_err,
    output logic                  o_cfg_err
);

    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MIN_LEN = CNT_W'(2);

    logic [SYNC_STAGES-1:0] r_sync_upd;
    logic [SYNC_STAGES-1:0] r_sync_dro;
    logic                   r_upd_last;
    logic                   r_dro_last;
    logic                   w_upd_rise;
    logic                   w_dro_fall;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [CNT_W-1:0]       r_plen;
    logic [CNT_W-1:0]       w_plen_nxt;
    logic                   r_sel;
    logic                   w_sel_nxt;
    logic [CNT_W-1:0]       r_wcnt;
    logic [CNT_W-1:0]       w_wcnt_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       w_half;
    logic                   w_set_cfg;
    logic                   w_set_to;

    logic                   r_drctl;
    logic                   r_drhold;
    logic                   r_osk;
    logic                   r_busy;
    logic                   r_timeout_err;
    logic                   r_cfg_err;

    // Synchronise the asynchronous trigger and DRG-over inputs, keep the
    // previous last-stage value for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_upd <= '0;
            r_sync_dro <= '0;
            r_upd_last <= 1'b0;
            r_dro_last <= 1'b0;
        end else begin
            r_sync_upd <= {r_sync_upd[SYNC_STAGES-2:0], i_io_update};
            r_sync_dro <= {r_sync_dro[SYNC_STAGES-2:0], i_drover};
            r_upd_last <= r_sync_upd[SYNC_STAGES-1];
            r_dro_last <= r_sync_dro[SYNC_STAGES-1];
        end
    end

    assign w_upd_rise = r_sync_upd[SYNC_STAGES-1] & ~r_upd_last;
    assign w_dro_fall = ~r_sync_dro[SYNC_STAGES-1] & r_dro_last;
    assign w_half     = r_plen >> 1;

    // Next-state, counter and error-set decode; dropping enable overrides all
    always_comb begin
        w_state_nxt = r_state;
        w_plen_nxt  = r_plen;
        w_sel_nxt   = r_sel;
        w_wcnt_nxt  = r_wcnt;
        w_cnt_nxt   = r_cnt;
        w_set_cfg   = 1'b0;
        w_set_to    = 1'b0;
        if (!i_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_upd_rise) begin
                        if (i_pulse_len >= c_MIN_LEN) begin
                            w_plen_nxt  = i_pulse_len;
                            w_sel_nxt   = i_sweep_sel;
                            w_wcnt_nxt  = '0;
                            w_state_nxt = ST_WAIT_DROVER;
                        end else begin
                            w_set_cfg = 1'b1;
                        end
                    end
                end
                ST_WAIT_DROVER: begin
                    w_wcnt_nxt = r_wcnt + c_ONE;
                    if (w_dro_fall) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_HALF1;
                    end else if (r_wcnt == c_TO_LAST) begin
                        w_set_to    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_HALF1: begin
                    w_cnt_nxt = r_cnt + c_ONE;
                    if (r_cnt == w_half - c_ONE) begin
                        w_state_nxt = ST_HALF2;
                    end
                end
                ST_HALF2: begin
                    w_cnt_nxt = r_cnt + c_ONE;
                    if (r_cnt == r_plen - c_ONE) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, latched configuration and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_plen  <= '0;
            r_sel   <= 1'b0;
            r_wcnt  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_plen  <= w_plen_nxt;
            r_sel   <= w_sel_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Pin outputs registered from the current state; sticky errors where a
    // new set in the same cycle as a clear keeps the flag high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drctl       <= 1'b0;
            r_drhold      <= 1'b0;
            r_osk         <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_drctl       <= (r_state == ST_WAIT_DROVER) || (r_state == ST_HALF1);
            r_drhold      <= ~i_en;
            r_osk         <= ((r_state == ST_HALF1) &&  r_sel) ||
                             ((r_state == ST_HALF2) && !r_sel);
            r_busy        <= (r_state != ST_IDLE);
            r_timeout_err <= w_set_to  ? 1'b1 : (i_err_clr ? 1'b0 : r_timeout_err);
            r_cfg_err     <= w_set_cfg ? 1'b1 : (i_err_clr ? 1'b0 : r_cfg_err);
        end
    end

    assign o_drctl       = r_drctl;
    assign o_drhold      = r_drhold;
    assign o_osk         = r_osk;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_timeout_err;
    assign o_cfg_err     = r_cfg_err;

endmodule
`default_nettype wire

// File: rtl/dds_time_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : dds_time_ctrl_mc
// Description : Multi-channel AD9910 trigger/timing controller. One
//               independent dds_time_chan per channel; pulse_len and err_clr
//               are shared.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_time_ctrl_mc
    import dds_time_pkg::*;
#(
    parameter int CH          = 2,
    parameter int CNT_W       = c_CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = c_TIMEOUT_DEF
) (
    input  wire logic          sys_clk,
    input  wire logic          sys_rst_n,
    dds_time_ctrl_mc_if.slave  bus
);

    logic [CH-1:0] w_drctl;
    logic [CH-1:0] w_drhold;
    logic [CH-1:0] w_osk;
    logic [CH-1:0] w_busy;
    logic [CH-1:0] w_timeout_err;
    logic [CH-1:0] w_cfg_err;

    generate
        for (genvar c = 0; c < CH; c++) begin : g_chan
            dds_time_chan #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES),
                .TIMEOUT     (TIMEOUT)
            ) u_chan (
                .clk           (sys_clk),
                .rst_n         (sys_rst_n),
                .i_en          (bus.en[c]),
                .i_sweep_sel   (bus.sweep_sel[c]),
                .i_pulse_len   (bus.pulse_len),
                .i_err_clr     (bus.err_clr),
                .i_io_update   (bus.io_update[c]),
                .i_drover      (bus.drover[c]),
                .o_drctl       (w_drctl[c]),
                .o_drhold      (w_drhold[c]),
                .o_osk         (w_osk[c]),
                .o_busy        (w_busy[c]),
                .o_timeout_err (w_timeout_err[c]),
                .o_cfg_err     (w_cfg_err[c])
            );
        end
    endgenerate

    assign bus.drctl       = w_drctl;
    assign bus.drhold      = w_drhold;
    assign bus.osk         = w_osk;
    assign bus.busy        = w_busy;
    assign bus.timeout_err = w_timeout_err;
    assign bus.cfg_err     = w_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_dds_time_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_time_ctrl_mc
// Description : Directed self-checking bench for dds_time_ctrl_mc (CH=2,
//               TIMEOUT=100). Inputs driven and outputs sampled on the
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_time_ctrl_mc;

    logic sys_clk;
    logic sys_rst_n;
    int   n_total;
    int   n_bad;

    dds_time_ctrl_mc_if #(.CH(2), .CNT_W(16)) bus ();

    dds_time_ctrl_mc #(
        .CH          (2),
        .CNT_W       (16),
        .SYNC_STAGES (2),
        .TIMEOUT     (100)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(negedge sys_clk);
    endtask

    // Trigger one channel, drop its drover after 'delay' samples and record
    // timing indices (relative to the drover drop) until busy falls.
    task automatic measure_pulse(input int ch, input int plen, input logic sel,
                                 input int delay, input int retrig_at,
                                 output int trig_idx, output int osk_first,
                                 output int osk_len, output int drctl_last,
                                 output int busy_last);
        trig_idx = -1; osk_first = -1; osk_len = 0; drctl_last = -1; busy_last = -1;
        bus.pulse_len     = 16'(plen);
        bus.sweep_sel[ch] = sel;
        bus.io_update[ch] = 1'b1;
        for (int k = 1; k <= delay; k++) begin
            tick();
            if (k == 1) bus.io_update[ch] = 1'b0;
            if (bus.drctl[ch] && trig_idx < 0) trig_idx = k;
        end
        bus.drover[ch] = 1'b0;
        for (int j = 1; j <= 3000; j++) begin
            tick();
            if (j == retrig_at)     bus.io_update[ch] = 1'b1;
            if (j == retrig_at + 1) bus.io_update[ch] = 1'b0;
            if (bus.osk[ch]) begin
                if (osk_first < 0) osk_first = j;
                osk_len++;
            end
            if (bus.drctl[ch]) drctl_last = j;
            if (!bus.busy[ch]) break;
            busy_last = j;
            if (j == 3000) busy_last = -1;
        end
        bus.drover[ch] = 1'b1;
        bus.io_update[ch] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b1;
        bus.en = 2'b11; bus.sweep_sel = 2'b00; bus.pulse_len = 16'd0;
        bus.err_clr = 1'b0; bus.io_update = 2'b00; bus.drover = 2'b11;
        #2 sys_rst_n = 1'b0;
        repeat (3) tick();
        n_total++;
        if ({bus.drctl, bus.osk, bus.busy} !== 6'b0) begin
            n_bad++; $display("FAIL reset_pins: got %b expected 000000", {bus.drctl, bus.osk, bus.busy});
        end
        n_total++;
        if ({bus.drhold, bus.timeout_err, bus.cfg_err} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 000000", {bus.drhold, bus.timeout_err, bus.cfg_err});
        end
        sys_rst_n = 1'b1;
        tick();
        n_total++;
        if (bus.drhold !== 2'b00 || bus.busy !== 2'b00) begin
            n_bad++; $display("FAIL post_reset_idle: drhold=%b busy=%b expected 00 00", bus.drhold, bus.busy);
        end
        repeat (4) tick();
    endtask

    task automatic test_pulse_long();
        int t, of, ol, dl, bl;
        measure_pulse(0, 1000, 1'b1, 50, 0, t, of, ol, dl, bl);
        n_total++; if (t != 4)    begin n_bad++; $display("FAIL long_trig_lat: got %0d expected 4", t); end
        n_total++; if (of != 4)   begin n_bad++; $display("FAIL long_osk_start: got %0d expected 4", of); end
        n_total++; if (ol != 500) begin n_bad++; $display("FAIL long_osk_len: got %0d expected 500", ol); end
        n_total++; if (dl != 503) begin n_bad++; $display("FAIL long_drctl_end: got %0d expected 503", dl); end
        n_total++; if (bl != 1003) begin n_bad++; $display("FAIL long_busy_end: got %0d expected 1003", bl); end
    endtask

    task automatic test_pulse_odd();
        int t, of, ol, dl, bl;
        measure_pulse(1, 7, 1'b0, 10, 0, t, of, ol, dl, bl);
        n_total++; if (t != 4)  begin n_bad++; $display("FAIL odd_trig_lat: got %0d expected 4", t); end
        n_total++; if (of != 7) begin n_bad++; $display("FAIL odd_osk_start: got %0d expected 7", of); end
        n_total++; if (ol != 4) begin n_bad++; $display("FAIL odd_osk_len: got %0d expected 4", ol); end
        n_total++; if (dl != 6) begin n_bad++; $display("FAIL odd_drctl_end: got %0d expected 6", dl); end
        n_total++; if (bl != 10) begin n_bad++; $display("FAIL odd_busy_end: got %0d expected 10", bl); end
    endtask

    task automatic test_timeout();
        int busy_last, to_first, osk_cnt;
        busy_last = -1; to_first = -1; osk_cnt = 0;
        bus.pulse_len = 16'd10; bus.sweep_sel[0] = 1'b1;
        bus.io_update[0] = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            tick();
            if (k == 1) bus.io_update[0] = 1'b0;
            if (bus.busy[0]) busy_last = k;
            if (bus.osk[0]) osk_cnt++;
            if (bus.timeout_err[0] && to_first < 0) to_first = k;
        end
        n_total++; if (busy_last != 103) begin n_bad++; $display("FAIL to_busy_end: got %0d expected 103", busy_last); end
        n_total++; if (to_first != 103) begin n_bad++; $display("FAIL to_flag_time: got %0d expected 103", to_first); end
        n_total++; if (osk_cnt != 0) begin n_bad++; $display("FAIL to_no_osk: got %0d expected 0", osk_cnt); end
        n_total++; if (bus.timeout_err !== 2'b01) begin n_bad++; $display("FAIL to_sticky: got %b expected 01", bus.timeout_err); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        n_total++; if (bus.timeout_err !== 2'b00) begin n_bad++; $display("FAIL to_clear: got %b expected 00", bus.timeout_err); end
        repeat (2) tick();
    endtask

    task automatic test_cfg_err();
        int busy_seen;
        busy_seen = 0;
        bus.pulse_len = 16'd1;
        bus.io_update[1] = 1'b1;
        tick();                         // N1
        bus.io_update[1] = 1'b0;
        tick();                         // N2: clear lands on the edge that sets the flag
        bus.err_clr = 1'b1;
        tick();                         // N3
        bus.err_clr = 1'b0;
        n_total++; if (bus.cfg_err !== 2'b10) begin n_bad++; $display("FAIL cfg_set_wins: got %b expected 10", bus.cfg_err); end
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.busy[1]) busy_seen++;
        end
        n_total++; if (busy_seen != 0) begin n_bad++; $display("FAIL cfg_stay_idle: busy cycles %0d expected 0", busy_seen); end
        n_total++; if (bus.cfg_err !== 2'b10) begin n_bad++; $display("FAIL cfg_sticky: got %b expected 10", bus.cfg_err); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        n_total++; if (bus.cfg_err !== 2'b00) begin n_bad++; $display("FAIL cfg_clear: got %b expected 00", bus.cfg_err); end
    endtask

    task automatic test_retrigger();
        int t, of, ol, dl, bl, late_busy;
        late_busy = 0;
        measure_pulse(0, 20, 1'b1, 10, 5, t, of, ol, dl, bl);
        n_total++; if (ol != 10) begin n_bad++; $display("FAIL retrig_osk_len: got %0d expected 10", ol); end
        n_total++; if (bl != 23) begin n_bad++; $display("FAIL retrig_busy_end: got %0d expected 23", bl); end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.busy[0]) late_busy++;
        end
        n_total++; if (late_busy != 0) begin n_bad++; $display("FAIL retrig_queued: busy cycles %0d expected 0", late_busy); end
    endtask

    task automatic test_dual();
        int first [2];
        int len [2];
        first = '{-1, -1}; len = '{0, 0};
        bus.pulse_len = 16'd10; bus.sweep_sel = 2'b01;
        bus.io_update = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) bus.io_update = 2'b00;
        end
        bus.drover = 2'b00;
        for (int j = 1; j <= 30; j++) begin
            tick();
            for (int c = 0; c < 2; c++) begin
                if (bus.osk[c]) begin
                    if (first[c] < 0) first[c] = j;
                    len[c]++;
                end
            end
        end
        bus.drover = 2'b11;
        n_total++; if (first[0] != 4) begin n_bad++; $display("FAIL dual_ch0_start: got %0d expected 4", first[0]); end
        n_total++; if (len[0] != 5)   begin n_bad++; $display("FAIL dual_ch0_len: got %0d expected 5", len[0]); end
        n_total++; if (first[1] != 9) begin n_bad++; $display("FAIL dual_ch1_start: got %0d expected 9", first[1]); end
        n_total++; if (len[1] != 5)   begin n_bad++; $display("FAIL dual_ch1_len: got %0d expected 5", len[1]); end
        repeat (4) tick();
    endtask

    task automatic test_en_drop();
        int len0, ch1_after, busy_last0;
        len0 = 0; ch1_after = 0; busy_last0 = -1;
        bus.pulse_len = 16'd100; bus.sweep_sel = 2'b11;
        bus.io_update = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) bus.io_update = 2'b00;
        end
        bus.drover = 2'b00;
        for (int j = 1; j <= 200; j++) begin
            tick();
            if (bus.osk[0]) len0++;
            if (bus.busy[0]) busy_last0 = j;
            if (j >= 12 && (bus.osk[1] || bus.drctl[1] || bus.busy[1])) ch1_after++;
            if (j == 12) begin
                n_total++;
                if (bus.osk[1] !== 1'b0 || bus.drctl[1] !== 1'b0) begin
                    n_bad++; $display("FAIL en_drop_ch1_low: osk=%b drctl=%b expected 0 0", bus.osk[1], bus.drctl[1]);
                end
                n_total++;
                if (bus.drhold !== 2'b10) begin n_bad++; $display("FAIL en_drop_drhold: got %b expected 10", bus.drhold); end
                n_total++;
                if (bus.osk[0] !== 1'b1 || bus.drctl[0] !== 1'b1) begin
                    n_bad++; $display("FAIL en_drop_ch0_kept: osk=%b drctl=%b expected 1 1", bus.osk[0], bus.drctl[0]);
                end
            end
            if (j == 10) bus.en[1] = 1'b0;
        end
        n_total++; if (len0 != 50) begin n_bad++; $display("FAIL en_drop_ch0_len: got %0d expected 50", len0); end
        n_total++; if (busy_last0 != 103) begin n_bad++; $display("FAIL en_drop_ch0_end: got %0d expected 103", busy_last0); end
        n_total++; if (ch1_after != 0) begin n_bad++; $display("FAIL en_drop_ch1_quiet: got %0d expected 0", ch1_after); end
        n_total++; if ({bus.timeout_err, bus.cfg_err} !== 4'b0) begin
            n_bad++; $display("FAIL en_drop_no_err: got %b expected 0000", {bus.timeout_err, bus.cfg_err});
        end
        bus.drover = 2'b11; bus.en = 2'b11;
        tick(); tick();
        n_total++; if (bus.drhold !== 2'b00) begin n_bad++; $display("FAIL en_restore_drhold: got %b expected 00", bus.drhold); end
        repeat (4) tick();
    endtask

    task automatic test_async_reset();
        int t, of, ol, dl, bl;
        bus.pulse_len = 16'd20; bus.sweep_sel[0] = 1'b0;
        bus.io_update[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) bus.io_update[0] = 1'b0;
        end
        bus.drover[0] = 1'b0;
        repeat (15) tick();
        n_total++; if (bus.osk[0] !== 1'b1) begin n_bad++; $display("FAIL rst_pre_half2_osk: got %b expected 1", bus.osk[0]); end
        sys_rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.drctl, bus.osk, bus.busy, bus.drhold} !== 8'b0) begin
            n_bad++; $display("FAIL rst_async_clear: got %b expected 00000000", {bus.drctl, bus.osk, bus.busy, bus.drhold});
        end
        bus.drover[0] = 1'b1;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        repeat (5) tick();
        measure_pulse(0, 7, 1'b0, 10, 0, t, of, ol, dl, bl);
        n_total++; if (of != 7 || ol != 4) begin n_bad++; $display("FAIL rst_recover_osk: start=%0d len=%0d expected 7 4", of, ol); end
        n_total++; if (bl != 10) begin n_bad++; $display("FAIL rst_recover_busy: got %0d expected 10", bl); end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_pulse_long();
        test_pulse_odd();
        test_timeout();
        test_cfg_err();
        test_retrigger();
        test_dual();
        test_en_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
